fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL expose: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL expose: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL expose: stall  input  1  hold PC and fetch register when high.
REQ-004 SHALL expose: branch_taken  input  1  redirect request from downstream stage.
REQ-005 SHALL expose: branch_target  input  32  byte address for redirect.
REQ-006 SHALL expose: halt  input  1  stop fetching until next reset.
REQ-007 SHALL expose: imem_addr  output  32  byte address to the instruction memory, equal to current PC.
REQ-008 SHALL expose: imem_data  input  32  combinational instruction word returned for imem_addr.
REQ-009 SHALL expose: instr_out  output  32  registered instruction to decode.
REQ-010 SHALL expose: pc_out  output  32  registered PC of instr_out.
REQ-011 SHALL expose: instr_valid  output  1  instr_out is a real instruction.
REQ-012 SHALL expose: fetch_count  output  16  saturating count of valid fetches.
REQ-013 Parameter RESET_PC, default 32'h0000_0000, meaning PC value after reset.

Function
REQ-014 imem_addr SHALL equal PC combinationally; PC[1:0] SHALL always be 2'b00.
REQ-015 FSM states SHALL be BOOT, RUN, HALTED; reset enters BOOT.
REQ-016 BOOT SHALL last exactly one cycle: instr_valid=0, PC unchanged, next state RUN.
REQ-017 In RUN with stall=0, branch_taken=0: PC <= PC+4; instr_out <= imem_data; pc_out <= PC; instr_valid <= 1; latency 1 cycle address-to-output.
REQ-018 In RUN with branch_taken=1: PC <= {branch_target[31:2],2'b00}; instr_out <= 0; instr_valid <= 0 (flush); pc_out unchanged.
REQ-019 branch_taken SHALL take priority over stall when both are high.
REQ-020 In RUN with stall=1, branch_taken=0: PC, instr_out, pc_out, instr_valid, fetch_count SHALL all hold.
REQ-021 halt=1 in RUN SHALL (priority over branch_taken and stall) move to HALTED; PC holds; instr_valid <= 0.
REQ-022 HALTED SHALL ignore stall, branch_taken, halt; exit only via reset.
REQ-023 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) without error.
REQ-024 fetch_count SHALL increment once per cycle in which instr_valid is loaded with 1, saturating at 16'hFFFF.

Reset
REQ-025 reset SHALL asynchronously force: PC=RESET_PC, instr_out=0, pc_out=0, instr_valid=0, fetch_count=0, state=BOOT.
REQ-026 reset asserted mid-branch, mid-stall or in HALTED SHALL discard all pending state; first fetch after release is RESET_PC after the BOOT cycle.

Structure
REQ-027 FSM state encodings, RESET_PC default and the 32'd4 increment constant SHALL live in the shared processor package.
REQ-028 One sub-module fetch_pc_reg (PC register with next-PC mux) SHALL be instantiated; the fetch register, FSM and counter reside in fetch_unit.

Verification
REQ-029 Reset release, memory preloaded with words W0..W3 -> cycle 1 BOOT (valid=0); cycles 2-5 instr_out=W0..W3, pc_out=0,4,8,12, fetch_count=4.
REQ-030 branch_taken=1, branch_target=32'h13 at PC=8 -> next imem_addr=32'h10, instr_valid=0 that cycle, following cycle instr_out=mem[4], pc_out=32'h10.
REQ-031 stall=1 for 3 cycles at PC=4 -> imem_addr, instr_out, pc_out, fetch_count unchanged for 3 cycles; fetch resumes at PC=4.
REQ-032 stall=1 and branch_taken=1 together, target 32'h0 -> PC=0, flush occurs; halt=1 then -> HALTED, PC frozen, instr_valid=0 for 10+ cycles despite toggling branch_taken.
REQ-033 RESET_PC=32'hFFFF_FFF8 -> pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-034 reset pulsed asynchronously mid-cycle during stall -> outputs zero immediately, imem_addr=RESET_PC before next clock edge.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared processor constants for the fetch stage
package fetch_unit_pkg;

  // Fetch FSM encodings
  localparam logic [1:0] ST_BOOT   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;

  // PC after reset unless overridden by the instantiating core
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Sequential fetch step (one 32-bit word)
  localparam logic [31:0] PC_INCR = 32'd4;

  // Saturation ceiling of the fetch counter
  localparam logic [15:0] FETCH_COUNT_MAX = 16'hFFFF;

  // Force a byte address onto a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter register with next-PC selection
module fetch_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_advance,
  input  logic        i_redirect,
  input  logic [31:0] i_target,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;

  // Redirect wins over sequential advance; otherwise hold. The add wraps
  // naturally at 2^32, and both sources keep the low two bits clear.
  always_comb begin
    w_pc_next = r_pc;
    if (i_redirect) begin
      w_pc_next = word_align(i_target);
    end else if (i_advance) begin
      w_pc_next = r_pc + PC_INCR;
    end
  end

  // PC state; the reset value is aligned so an odd RESET_PC cannot leak out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= word_align(RESET_PC);
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with boot/run/halt control
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic [15:0] fetch_count
);

  logic [1:0]  r_state;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic        r_valid;
  logic [15:0] r_count;

  logic [31:0] w_pc;
  logic        w_run;
  logic        w_halt_go;
  logic        w_redirect;
  logic        w_advance;

  // Priority in RUN: halt, then branch, then stall, then sequential fetch
  assign w_run      = (r_state == ST_RUN);
  assign w_halt_go  = w_run && halt;
  assign w_redirect = w_run && !halt && branch_taken;
  assign w_advance  = w_run && !halt && !branch_taken && !stall;

  fetch_pc_reg #(
    .RESET_PC   (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .i_advance  (w_advance),
    .i_redirect (w_redirect),
    .i_target   (branch_target),
    .o_pc       (w_pc)
  );

  assign imem_addr = w_pc;

  // Control FSM: one BOOT cycle after reset, HALTED is left only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_BOOT;
    end else begin
      case (r_state)
        ST_BOOT:   r_state <= ST_RUN;
        ST_RUN:    r_state <= halt ? ST_HALTED : ST_RUN;
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_BOOT;
      endcase
    end
  end

  // Fetch register: capture on advance, flush on redirect, drop valid on halt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr  <= 32'h0;
      r_pc_out <= 32'h0;
      r_valid  <= 1'b0;
    end else if (w_advance) begin
      r_instr  <= imem_data;
      r_pc_out <= w_pc;
      r_valid  <= 1'b1;
    end else if (w_redirect) begin
      r_instr  <= 32'h0;
      r_valid  <= 1'b0;
    end else if (w_halt_go) begin
      r_valid  <= 1'b0;
    end
  end

  // Saturating count of cycles that load a valid instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 16'h0;
    end else if (w_advance && (r_count != FETCH_COUNT_MAX)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign instr_out   = r_instr;
  assign pc_out      = r_pc_out;
  assign instr_valid = r_valid;
  assign fetch_count = r_count;

endmodule
